// File: rtl/hazard_ctrl_pkg.sv
// ============================================================================
// Module      : hazard_ctrl_pkg
// Description : Shared types and constants for the pipeline hazard controller.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        FLUSH  = 2'd1,
        FREEZE = 2'd2
    } hc_state_t;

    localparam int HC_FLUSH_W        = 3;
    localparam int HC_FETCH_LAT_MIN  = 1;
    localparam int HC_FETCH_LAT_MAX  = 8;

    // Out-of-range latencies are clamped so the flush count always fits HC_FLUSH_W.
    function automatic logic [HC_FLUSH_W-1:0] hc_flush_init(input int lat);
        int l;
        l = lat;
        if (l < HC_FETCH_LAT_MIN) l = HC_FETCH_LAT_MIN;
        if (l > HC_FETCH_LAT_MAX) l = HC_FETCH_LAT_MAX;
        l = l - 1;
        return l[HC_FLUSH_W-1:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_ctrl_sat.sv
// ============================================================================
// Module      : sat_counter
// Description : Saturating up-counter with synchronous clear.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] c_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + c_ONE;
        end
    end

    assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ============================================================================
// Module      : hazard_ctrl
// Description : Stall/flush/freeze sequencing for the 5-stage RISC pipeline.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_AW    = 5,
    parameter int FETCH_LAT = 2,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_mem_read,
    input  logic              ex_branch_taken,
    input  logic              dmem_busy,
    input  logic              perf_clr,
    output logic              pc_en,
    output logic              pc_redirect,
    output logic              ifid_en,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic              exmem_en,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  flush_events
);

    localparam logic [HC_FLUSH_W-1:0] c_FLUSH_INIT = hc_flush_init(FETCH_LAT);
    localparam logic [HC_FLUSH_W-1:0] c_FLUSH_ONE  = HC_FLUSH_W'(1);

    hc_state_t             r_state;
    hc_state_t             w_state_nxt;
    hc_state_t             w_eff_state;
    logic [HC_FLUSH_W-1:0] r_flush_left;
    logic [HC_FLUSH_W-1:0] w_flush_left_nxt;

    logic w_load_use;
    logic w_branch_acc;
    logic w_pc_en;
    logic w_pc_redirect;
    logic w_ifid_en;
    logic w_ifid_flush;
    logic w_idex_flush;
    logic w_exmem_en;

    assign w_load_use = ex_mem_read && (ex_rd != '0) &&
                        ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                         (id_uses_rs2 && (id_rs2 == ex_rd)));

    always_comb begin
        // An unbusy FREEZE cycle already behaves as the state it resumes into.
        w_eff_state = r_state;
        if (r_state == FREEZE) begin
            w_eff_state = (r_flush_left != '0) ? FLUSH : RUN;
        end

        w_state_nxt      = w_eff_state;
        w_flush_left_nxt = r_flush_left;
        w_branch_acc     = 1'b0;
        w_pc_en          = 1'b1;
        w_pc_redirect    = 1'b0;
        w_ifid_en        = 1'b1;
        w_ifid_flush     = 1'b0;
        w_idex_flush     = 1'b0;
        w_exmem_en       = 1'b1;

        if (!rst_n) begin
            w_state_nxt      = RUN;
            w_flush_left_nxt = '0;
            w_pc_en          = 1'b0;
            w_ifid_en        = 1'b0;
            w_exmem_en       = 1'b0;
            w_ifid_flush     = 1'b1;
            w_idex_flush     = 1'b1;
        end else if (dmem_busy) begin
            w_state_nxt = FREEZE;
            w_pc_en     = 1'b0;
            w_ifid_en   = 1'b0;
            w_exmem_en  = 1'b0;
        end else if (ex_branch_taken) begin
            w_branch_acc     = 1'b1;
            w_pc_redirect    = 1'b1;
            w_ifid_flush     = 1'b1;
            w_idex_flush     = 1'b1;
            w_flush_left_nxt = c_FLUSH_INIT;
            w_state_nxt      = (c_FLUSH_INIT != '0) ? FLUSH : RUN;
        end else if (w_eff_state == FLUSH) begin
            w_ifid_flush     = 1'b1;
            w_flush_left_nxt = r_flush_left - c_FLUSH_ONE;
            w_state_nxt      = (r_flush_left == c_FLUSH_ONE) ? RUN : FLUSH;
        end else if (w_load_use) begin
            w_pc_en      = 1'b0;
            w_ifid_en    = 1'b0;
            w_idex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= RUN;
            r_flush_left <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_flush_left <= w_flush_left_nxt;
        end
    end

    assign pc_en       = w_pc_en;
    assign pc_redirect = w_pc_redirect;
    assign ifid_en     = w_ifid_en;
    assign ifid_flush  = w_ifid_flush;
    assign idex_flush  = w_idex_flush;
    assign exmem_en    = w_exmem_en;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (!w_pc_en),
        .clr   (perf_clr),
        .count (stall_cycles)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_branch_acc),
        .clr   (perf_clr),
        .count (flush_events)
    );

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Directed scoreboard bench for hazard_ctrl (three parameter sets).
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken, dmem_busy, perf_clr;

    // Control vector order: {pc_en, pc_redirect, ifid_en, ifid_flush, idex_flush, exmem_en}
    localparam logic [5:0] C_RST = 6'b000110;
    localparam logic [5:0] C_RUN = 6'b101001;
    localparam logic [5:0] C_STL = 6'b000011;
    localparam logic [5:0] C_BR  = 6'b111111;
    localparam logic [5:0] C_FL  = 6'b101101;
    localparam logic [5:0] C_FRZ = 6'b000000;

    logic        pc_en_m, redir_m, ifid_en_m, ifid_fl_m, idex_fl_m, exmem_en_m;
    logic [15:0] stall_m, flush_m;
    logic        pc_en_1, redir_1, ifid_en_1, ifid_fl_1, idex_fl_1, exmem_en_1;
    logic [15:0] stall_1, flush_1;
    logic        pc_en_4, redir_4, ifid_en_4, ifid_fl_4, idex_fl_4, exmem_en_4;
    logic [3:0]  stall_4, flush_4;

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_AW(5), .FETCH_LAT(2), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
        .dmem_busy(dmem_busy), .perf_clr(perf_clr),
        .pc_en(pc_en_m), .pc_redirect(redir_m), .ifid_en(ifid_en_m),
        .ifid_flush(ifid_fl_m), .idex_flush(idex_fl_m), .exmem_en(exmem_en_m),
        .stall_cycles(stall_m), .flush_events(flush_m));

    hazard_ctrl #(.REG_AW(5), .FETCH_LAT(1), .CNT_W(16)) u_dut_lat1 (
        .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
        .dmem_busy(dmem_busy), .perf_clr(perf_clr),
        .pc_en(pc_en_1), .pc_redirect(redir_1), .ifid_en(ifid_en_1),
        .ifid_flush(ifid_fl_1), .idex_flush(idex_fl_1), .exmem_en(exmem_en_1),
        .stall_cycles(stall_1), .flush_events(flush_1));

    hazard_ctrl #(.REG_AW(5), .FETCH_LAT(2), .CNT_W(4)) u_dut_cnt4 (
        .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
        .dmem_busy(dmem_busy), .perf_clr(perf_clr),
        .pc_en(pc_en_4), .pc_redirect(redir_4), .ifid_en(ifid_en_4),
        .ifid_flush(ifid_fl_4), .idex_flush(idex_fl_4), .exmem_en(exmem_en_4),
        .stall_cycles(stall_4), .flush_events(flush_4));

    // Observation units: 0 main ctl, 1 lat1 ctl, 2 main stall, 3 main flush, 4 cnt4 stall, 5 cnt4 ctl
    typedef struct {
        string       tag;
        int          unit;
        logic [15:0] val;
    } chk_t;

    chk_t q_now[$];
    chk_t q_next[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic logic [15:0] observe(input int unit);
        case (unit)
            0:       return {10'b0, pc_en_m, redir_m, ifid_en_m, ifid_fl_m, idex_fl_m, exmem_en_m};
            1:       return {10'b0, pc_en_1, redir_1, ifid_en_1, ifid_fl_1, idex_fl_1, exmem_en_1};
            2:       return stall_m;
            3:       return flush_m;
            4:       return {12'b0, stall_4};
            default: return {10'b0, pc_en_4, redir_4, ifid_en_4, ifid_fl_4, idex_fl_4, exmem_en_4};
        endcase
    endfunction

    task automatic compare(input chk_t c);
        logic [15:0] obs;
        obs = observe(c.unit);
        n_cmp++;
        assert (obs === c.val) else begin
            n_bad++;
            $error("FAIL %s (unit %0d): observed %0h expected %0h", c.tag, c.unit, obs, c.val);
        end
    endtask

    task automatic exp_now(input string tag, input int unit, input logic [15:0] val);
        q_now.push_back('{tag, unit, val});
    endtask

    task automatic exp_next(input string tag, input int unit, input logic [15:0] val);
        q_next.push_back('{tag, unit, val});
    endtask

    task automatic settle();
        #1;
        while (q_now.size() > 0) compare(q_now.pop_front());
    endtask

    // One clock cycle: combinational checks before the edge, registered checks after it.
    task automatic cyc(input string tag, input logic [5:0] ctl);
        exp_now(tag, 0, {10'b0, ctl});
        exp_now({tag, "_c4"}, 5, {10'b0, ctl});
        settle();
        @(negedge clk);
        while (q_next.size() > 0) compare(q_next.pop_front());
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
        id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_mem_read = 1'b0;
        ex_branch_taken = 1'b0; dmem_busy = 1'b0; perf_clr = 1'b0;

        @(negedge clk);
        exp_now("rst_stall", 2, 16'd0);
        exp_now("rst_flush", 3, 16'd0);
        cyc("rst0", C_RST);
        exp_next("rst_nocount", 2, 16'd0);
        cyc("rst1", C_RST);

        rst_n = 1'b1;
        cyc("idle", C_RUN);

        // Load-use on rs2
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
        exp_next("lu_stall_cnt", 2, 16'd1);
        cyc("lu_rs2", C_STL);
        ex_mem_read = 1'b0;
        exp_next("lu_stall_hold", 2, 16'd1);
        cyc("lu_clear", C_RUN);

        // x0 destination never stalls
        ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs2 = 5'd0;
        cyc("lu_x0", C_RUN);

        // rs1 match, then match with the source unused
        ex_rd = 5'd7; id_rs1 = 5'd7; id_uses_rs1 = 1'b1; id_uses_rs2 = 1'b0;
        exp_next("lu_rs1_cnt", 2, 16'd2);
        cyc("lu_rs1", C_STL);
        id_uses_rs1 = 1'b0;
        cyc("lu_unused", C_RUN);
        ex_mem_read = 1'b0;

        // Branch with FETCH_LAT=2, and FETCH_LAT=1 never entering FLUSH
        ex_branch_taken = 1'b1;
        exp_now("br_lat1", 1, {10'b0, C_BR});
        exp_next("br_flush_cnt", 3, 16'd1);
        cyc("br", C_BR);
        ex_branch_taken = 1'b0;
        ex_mem_read = 1'b1; ex_rd = 5'd3; id_rs1 = 5'd3; id_uses_rs1 = 1'b1;
        exp_now("br2_lat1", 1, {10'b0, C_STL});
        exp_next("br2_nostall", 2, 16'd2);
        cyc("br2_flush", C_FL);
        ex_mem_read = 1'b0; id_uses_rs1 = 1'b0;
        exp_now("br3_lat1", 1, {10'b0, C_RUN});
        exp_next("br3_flush_cnt", 3, 16'd1);
        cyc("br3_run", C_RUN);

        // Freeze starting in the FLUSH cycle
        perf_clr = 1'b1;
        exp_next("clr_stall", 2, 16'd0);
        exp_next("clr_flush", 3, 16'd0);
        cyc("clr", C_RUN);
        perf_clr = 1'b0;
        ex_branch_taken = 1'b1;
        cyc("fz_br", C_BR);
        ex_branch_taken = 1'b0;
        dmem_busy = 1'b1;
        for (int i = 0; i < 3; i++) cyc("fz_hold", C_FRZ);
        dmem_busy = 1'b0;
        exp_next("fz_stall_cnt", 2, 16'd3);
        exp_next("fz_flush_cnt", 3, 16'd1);
        cyc("fz_resume_flush", C_FL);
        cyc("fz_run", C_RUN);

        // Busy and branch together
        dmem_busy = 1'b1; ex_branch_taken = 1'b1;
        cyc("sb_frz0", C_FRZ);
        exp_next("sb_no_count", 3, 16'd1);
        cyc("sb_frz1", C_FRZ);
        dmem_busy = 1'b0;
        exp_next("sb_flush_cnt", 3, 16'd2);
        cyc("sb_br", C_BR);
        ex_branch_taken = 1'b0;
        cyc("sb_flush", C_FL);
        exp_next("sb_flush_hold", 3, 16'd2);
        exp_next("sb_stall_cnt", 2, 16'd5);
        cyc("sb_run", C_RUN);

        // Saturation with CNT_W=4, then clear during busy
        perf_clr = 1'b1;
        exp_next("sat_clr", 4, 16'd0);
        cyc("sat_clr", C_RUN);
        perf_clr = 1'b0;
        dmem_busy = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            exp_next("sat_cnt4", 4, (k > 15) ? 16'd15 : 16'(k));
            cyc("sat_busy", C_FRZ);
        end
        exp_now("sat_main", 2, 16'd20);
        perf_clr = 1'b1;
        exp_next("sat_clr_wins4", 4, 16'd0);
        exp_next("sat_clr_wins", 2, 16'd0);
        cyc("sat_clr_busy", C_FRZ);
        perf_clr = 1'b0;
        exp_next("sat_restart", 4, 16'd1);
        cyc("frz_pre_rst", C_FRZ);

        // Asynchronous reset between edges while frozen
        #2;
        rst_n = 1'b0;
        exp_now("arst_ctl", 0, {10'b0, C_RST});
        exp_now("arst_stall", 2, 16'd0);
        exp_now("arst_stall4", 4, 16'd0);
        settle();
        @(negedge clk);
        rst_n = 1'b1; dmem_busy = 1'b0;
        exp_next("arst_after", 2, 16'd0);
        cyc("arst_run", C_RUN);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and sequencing controller for the 5-stage RISC core. It drives hold/flush for the PC, the IF/ID register, the ID/EX bubble and the EX/MEM enable. It resolves load-use stalls, taken-branch flushes (including stale fetches from a registered instruction memory) and data-memory wait freezes. It also maintains saturating stall/flush performance counters.

## Interface
- `REG_AW`, 5: register-address width.
- `FETCH_LAT`, 2: instruction-fetch latency in cycles, range 1..8; branch flush lasts `FETCH_LAT` cycles.
- `CNT_W`, 16: performance-counter width.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `id_rs1`, `id_rs2` in `REG_AW`: source registers of the instruction in ID.
- `id_uses_rs1`, `id_uses_rs2` in 1: source actually read.
- `ex_rd` in `REG_AW`: destination register of the instruction in EX.
- `ex_mem_read` in 1: EX instruction is a load.
- `ex_branch_taken` in 1: taken branch/jump resolved in EX this cycle.
- `dmem_busy` in 1: data memory not ready; the pipeline must freeze.
- `perf_clr` in 1: synchronous clear of both counters.
- `pc_en` out 1: PC register update enable.
- `pc_redirect` out 1: select branch target into PC.
- `ifid_en` out 1: IF/ID load enable.
- `ifid_flush` out 1: IF/ID clear to NOP.
- `idex_flush` out 1: insert bubble into ID/EX.
- `exmem_en` out 1: EX/MEM and later stage enable.
- `stall_cycles` out `CNT_W`: cycles with `pc_en`=0 after reset.
- `flush_events` out `CNT_W`: accepted taken branches.

## Operation
- States:
  - RUN: normal operation.
  - FLUSH: draining stale fetches.
  - FREEZE: memory wait.
- Register `flush_left` is 3 bits and counts remaining post-branch flush cycles.
- Priority per cycle: `dmem_busy` > `ex_branch_taken` > load-use.
- FREEZE, or any state with `dmem_busy`=1:
  - `pc_en`, `ifid_en` and `exmem_en` are 0.
  - All flushes and `pc_redirect` are 0.
  - `flush_left` holds.
  - Next state is FREEZE while busy.
  - On release, next state is FLUSH if `flush_left`≠0, else RUN.
- Branch, in RUN or FLUSH with `ex_branch_taken`=1 and not busy:
  - `pc_en`=1 and `pc_redirect`=1.
  - `ifid_flush`=1 and `idex_flush`=1.
  - `flush_left` ← `FETCH_LAT`−1; next state is FLUSH if that value is nonzero, else RUN.
  - `flush_events` increments.
- FLUSH without branch or busy:
  - `ifid_flush`=1 and `pc_en`=1.
  - `flush_left` decrements; state returns to RUN when it reaches 0.
  - Load-use detection is suppressed because ID holds a bubble.
- Load-use, in RUN, not busy, no branch:
  - Condition: `ex_mem_read` & `ex_rd`≠0 & ((`id_uses_rs1` & `id_rs1`==`ex_rd`) | (`id_uses_rs2` & `id_rs2`==`ex_rd`)).
  - Response: `pc_en`=0, `ifid_en`=0, `idex_flush`=1, `exmem_en`=1.
  - State stays RUN; the hazard self-clears next cycle as the load advances.
- Default in RUN: all enables 1, all flush/redirect 0.
- `ifid_en`=1 whenever `ifid_flush`=1.
- Counters:
  - Saturate at all-ones; never wrap.
  - `perf_clr` wins over increment in the same cycle.
  - `stall_cycles` increments on every cycle with `pc_en`=0 while `rst_n`=1.
- `ex_branch_taken` held during a freeze is accepted once, in the first unfrozen cycle. EX is frozen, so no double count occurs.

## Timing
- All outputs are combinational from state, `flush_left` and the current inputs; zero-cycle latency to hazard response.
- `stall_cycles` and `flush_events` are registered and reflect the event one cycle later.
- While `rst_n`=0:
  - State is RUN; `flush_left`=0; counters are 0.
  - `pc_en`, `ifid_en`, `exmem_en` and `pc_redirect` are 0.
  - `ifid_flush` and `idex_flush` are 1.
  - `stall_cycles` does not count.
- Reset asserted mid-FLUSH or mid-FREEZE aborts the operation immediately. The first cycle after release is RUN.
- With `FETCH_LAT`=2, a branch gives 2 `ifid_flush` cycles: the branch cycle plus one FLUSH cycle.
- With `FETCH_LAT`=1, the FLUSH state is never entered.

## Structure
- Package `hazard_ctrl_pkg` holds:
  - the state enum `hc_state_t` {RUN, FLUSH, FREEZE};
  - localparam `HC_FLUSH_W`=3;
  - the `FETCH_LAT` legal-range check constant.
- One sub-module `sat_counter` (`CNT_W`, `inc`, `clr`, async active-low reset) is instantiated twice for the performance counters.
- Next-state/output decode stays inline in `hazard_ctrl`.

## Test plan
- **Load-use:**
  - Stimulus: `ex_mem_read`=1, `ex_rd`=5, `id_rs2`=5, `id_uses_rs2`=1.
  - Expect one cycle with `pc_en`=0, `ifid_en`=0, `idex_flush`=1.
  - Expect `stall_cycles`=1 the next cycle.
  - Repeat with `ex_rd`=0: expect no stall.
- **Branch, `FETCH_LAT`=2:**
  - Pulse `ex_branch_taken` for 1 cycle.
  - Expect `pc_redirect`=1 for 1 cycle, `ifid_flush`=1 for exactly 2 cycles, `flush_events`=1.
  - A load-use match during the second cycle must not stall.
- **Freeze mid-flush:**
  - Raise `dmem_busy` for 3 cycles starting in the FLUSH cycle.
  - Expect all enables 0 for 3 cycles, then 1 remaining `ifid_flush` cycle, then RUN.
  - Expect `stall_cycles`=3.
- **Simultaneous busy and branch:**
  - Hold both high for 2 cycles, then drop `dmem_busy`.
  - Expect redirect only in the first unfrozen cycle and `flush_events`=1.
- **Saturation and clear:**
  - With `CNT_W`=4, hold `dmem_busy` for 20 cycles.
  - Expect `stall_cycles`=15 and held.
  - Assert `perf_clr` together with busy: expect 0.
- **Async reset:**
  - Drop `rst_n` mid-FREEZE, between clock edges.
  - Expect outputs to go immediately to the reset values.
  - After release: RUN with `pc_en`=1.
